// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the memory port arbiter
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_t;

    // Wide enough for any byte-enable width; users slice the low BE_W bits.
    localparam logic [127:0] MEM_BE_ALL = '1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester, memory and status signals of the port arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_W-1:0]     if_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W/8-1:0]   d_be;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_W-1:0]     d_rdata;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_be;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [DATA_W-1:0]     mem_rdata;

    logic                  busy;
    logic                  err;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be, busy, err
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be, busy, err
    );
endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// rtl/mem_port_arbiter_rr_arb2.sv - combinational 2-way round-robin pick
module rr_arb2
    import cpu_pkg::*;
(
    input  logic       req_if_i,
    input  logic       req_d_i,
    input  logic       mask_if_i,
    input  logic       mask_d_i,
    input  arb_owner_t last_owner_i,
    output logic       valid_o,
    output arb_owner_t winner_o
);
    logic act_if;
    logic act_d;

    always_comb begin
        act_if   = req_if_i & ~mask_if_i;
        act_d    = req_d_i & ~mask_d_i;
        valid_o  = act_if | act_d;
        winner_o = OWN_IF;
        if (act_d && !act_if) begin
            winner_o = OWN_D;
        end else if (act_d && act_if && last_owner_i == OWN_IF) begin
            winner_o = OWN_D;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and load/store, round-robin
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    arb_state_t          state_q, state_d;
    arb_owner_t          owner_q, owner_d;
    arb_owner_t          last_owner_q, last_owner_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                if_gnt_q, if_gnt_d;
    logic                d_gnt_q, d_gnt_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0]     mem_be_q, mem_be_d;

    logic                in_rsp;
    logic                timeout_hit;
    logic                done;
    logic                load;
    logic                arb_valid;
    arb_owner_t          arb_winner;

    // The completing owner is masked so the other side gets the port back-to-back.
    rr_arb2 u_rr_arb2 (
        .req_if_i     (bus.if_req),
        .req_d_i      (bus.d_req),
        .mask_if_i    (in_rsp && owner_q == OWN_IF),
        .mask_d_i     (in_rsp && owner_q == OWN_D),
        .last_owner_i (last_owner_q),
        .valid_o      (arb_valid),
        .winner_o     (arb_winner)
    );

    always_comb begin
        in_rsp      = (state_q == RSP);
        timeout_hit = (TIMEOUT_CYC != 0) && in_rsp && !bus.mem_rvalid
                      && (cnt_q == CNT_W'(TIMEOUT_CYC));
        done        = in_rsp && (bus.mem_rvalid || timeout_hit);
    end

    always_comb begin
        bus.mem_req   = (state_q == REQ);
        bus.busy      = (state_q != IDLE);
        bus.err       = timeout_hit;
        bus.if_gnt    = if_gnt_q;
        bus.d_gnt     = d_gnt_q;
        bus.mem_we    = mem_we_q;
        bus.mem_addr  = mem_addr_q;
        bus.mem_wdata = mem_wdata_q;
        bus.mem_be    = mem_be_q;
        bus.if_rvalid = done && owner_q == OWN_IF;
        bus.d_rvalid  = done && owner_q == OWN_D;
        bus.if_rdata  = (in_rsp && owner_q == OWN_IF && !timeout_hit) ? bus.mem_rdata : '0;
        bus.d_rdata   = (in_rsp && owner_q == OWN_D && !timeout_hit) ? bus.mem_rdata : '0;
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        if_gnt_d     = 1'b0;
        d_gnt_d      = 1'b0;
        load         = 1'b0;
        unique case (state_q)
            IDLE: begin
                load = arb_valid;
            end
            REQ: begin
                if (bus.mem_gnt) begin
                    state_d  = RSP;
                    cnt_d    = '0;
                    if_gnt_d = (owner_q == OWN_IF);
                    d_gnt_d  = (owner_q == OWN_D);
                end
            end
            RSP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (done) begin
                    last_owner_d = owner_q;
                    load         = arb_valid && !timeout_hit;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            state_d = REQ;
            owner_d = arb_winner;
        end
    end

    always_comb begin
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if (load) begin
            if (arb_winner == OWN_IF) begin
                mem_we_d    = 1'b0;
                mem_addr_d  = bus.if_addr;
                mem_wdata_d = '0;
                mem_be_d    = MEM_BE_ALL[BE_W-1:0];
            end else begin
                mem_we_d    = bus.d_we;
                mem_addr_d  = bus.d_addr;
                mem_wdata_d = bus.d_wdata;
                mem_be_d    = bus.d_be;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= OWN_IF;
            last_owner_q <= OWN_D;
            cnt_q        <= '0;
            if_gnt_q     <= 1'b0;
            d_gnt_q      <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            if_gnt_q     <= if_gnt_d;
            d_gnt_q      <= d_gnt_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;
    localparam int NV = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic rs, ir, dr, dw, mg, mv;
        logic [31:0] ia, da, dwd, md;
        logic [3:0] dbe;
    } in_t;

    typedef struct {
        logic mreq, busy, ig, dg, iv, dv, err, we;
        logic [31:0] ird, drd, addr, wd;
        logic [3:0] be;
    } ex_t;

    in_t vin[NV];
    ex_t vex[NV];

    function automatic in_t mk_in(int rs, int ir, int ia, int dr, int dw, int da, int dwd,
                                  int dbe, int mg, int mv, int md);
        in_t v;
        v.rs = (rs != 0); v.ir = (ir != 0); v.dr = (dr != 0); v.dw = (dw != 0);
        v.mg = (mg != 0); v.mv = (mv != 0);
        v.ia = ia; v.da = da; v.dwd = dwd; v.md = md; v.dbe = 4'(dbe);
        return v;
    endfunction

    function automatic ex_t mk_ex(int mreq, int busy, int ig, int dg, int iv, int dv, int err,
                                  int ird, int drd, int we, int addr, int wd, int be);
        ex_t e;
        e.mreq = (mreq != 0); e.busy = (busy != 0); e.ig = (ig != 0); e.dg = (dg != 0);
        e.iv = (iv != 0); e.dv = (dv != 0); e.err = (err != 0); e.we = (we != 0);
        e.ird = ird; e.drd = drd; e.addr = addr; e.wd = wd; e.be = 4'(be);
        return e;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        chk1({tag, " busy"}, bus.busy, 1'b0);
        chk1({tag, " mem_req"}, bus.mem_req, 1'b0);
        chk1({tag, " mem_we"}, bus.mem_we, 1'b0);
        chk32({tag, " mem_addr"}, bus.mem_addr, 32'h0);
        chk32({tag, " mem_wdata"}, bus.mem_wdata, 32'h0);
        chk32({tag, " mem_be"}, 32'(bus.mem_be), 32'h0);
        chk1({tag, " if_gnt"}, bus.if_gnt, 1'b0);
        chk1({tag, " d_gnt"}, bus.d_gnt, 1'b0);
        chk1({tag, " if_rvalid"}, bus.if_rvalid, 1'b0);
        chk1({tag, " d_rvalid"}, bus.d_rvalid, 1'b0);
        chk32({tag, " if_rdata"}, bus.if_rdata, 32'h0);
        chk32({tag, " d_rdata"}, bus.d_rdata, 32'h0);
        chk1({tag, " err"}, bus.err, 1'b0);
    endtask

    // Reference model state: transaction view of the port.
    bit          m_busy, m_granted, m_ig, m_dg, m_we;
    int          m_own, m_prev, m_wait;
    logic [31:0] m_addr, m_wd;
    logic [3:0]  m_be;
    bit          rq_if, rq_d, rq_dw;
    logic [31:0] rq_ia, rq_da, rq_dwd;
    logic [3:0]  rq_dbe;

    function automatic int pick(bit a, bit b, int prev);
        if (a && b) return (prev == 0) ? 1 : 0;
        if (a) return 0;
        if (b) return 1;
        return -1;
    endfunction

    task automatic model_start(input int w);
        m_busy = 1; m_granted = 0; m_own = w;
        if (w == 0) begin
            m_we = 0; m_addr = rq_ia; m_wd = 0; m_be = 4'hF;
        end else begin
            m_we = rq_dw; m_addr = rq_da; m_wd = rq_dwd; m_be = rq_dbe;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int owners[$];
        int bubbles;
        int first;

        idle_inputs();

        // Single fetch, tie after reset, store with stalled grant.
        vin[0]  = mk_in(0,0,0,0,0,0,0,0,0,0,0);                     vex[0]  = mk_ex(0,0,0,0,0,0,0,0,0,0,0,0,0);
        vin[1]  = mk_in(1,1,'h100,0,0,0,0,0,0,1,'h5A5A);            vex[1]  = mk_ex(0,0,0,0,0,0,0,0,0,0,0,0,0);
        vin[2]  = mk_in(1,1,'h100,0,0,0,0,0,1,1,'h5A5A);            vex[2]  = mk_ex(1,1,0,0,0,0,0,0,0,0,'h100,0,'hF);
        vin[3]  = mk_in(1,1,'h100,0,0,0,0,0,0,0,0);                 vex[3]  = mk_ex(0,1,1,0,0,0,0,0,0,0,0,0,0);
        vin[4]  = mk_in(1,1,'h100,0,0,0,0,0,0,1,'h00500093);        vex[4]  = mk_ex(0,1,0,0,1,0,0,'h00500093,0,0,0,0,0);
        vin[5]  = mk_in(1,0,0,0,0,0,0,0,0,0,0);                     vex[5]  = mk_ex(0,0,0,0,0,0,0,0,0,0,0,0,0);
        vin[6]  = mk_in(0,0,0,0,0,0,0,0,0,0,0);                     vex[6]  = mk_ex(0,0,0,0,0,0,0,0,0,0,0,0,0);
        vin[7]  = mk_in(1,1,'h300,1,0,'h200,0,'hF,0,0,0);           vex[7]  = mk_ex(0,0,0,0,0,0,0,0,0,0,0,0,0);
        vin[8]  = mk_in(1,1,'h300,1,0,'h200,0,'hF,1,0,0);           vex[8]  = mk_ex(1,1,0,0,0,0,0,0,0,0,'h300,0,'hF);
        vin[9]  = mk_in(1,1,'h300,1,0,'h200,0,'hF,0,1,'h11111111);  vex[9]  = mk_ex(0,1,1,0,1,0,0,'h11111111,0,0,0,0,0);
        vin[10] = mk_in(1,0,0,1,0,'h200,0,'hF,1,0,0);               vex[10] = mk_ex(1,1,0,0,0,0,0,0,0,0,'h200,0,'hF);
        vin[11] = mk_in(1,0,0,1,0,'h200,0,'hF,0,1,'h22222222);      vex[11] = mk_ex(0,1,0,1,0,1,0,0,'h22222222,0,0,0,0);
        vin[12] = mk_in(1,0,0,0,0,0,0,0,0,0,0);                     vex[12] = mk_ex(0,0,0,0,0,0,0,0,0,0,0,0,0);
        vin[13] = mk_in(1,0,0,1,1,'h40,'hDEADBEEF,3,0,0,0);         vex[13] = mk_ex(0,0,0,0,0,0,0,0,0,0,0,0,0);
        vin[14] = mk_in(1,0,0,1,1,'h40,'hDEADBEEF,3,0,0,0);         vex[14] = mk_ex(1,1,0,0,0,0,0,0,0,1,'h40,'hDEADBEEF,3);
        vin[15] = mk_in(1,0,0,1,1,'h40,'hDEADBEEF,3,0,0,0);         vex[15] = mk_ex(1,1,0,0,0,0,0,0,0,1,'h40,'hDEADBEEF,3);
        vin[16] = mk_in(1,0,0,1,1,'h40,'hDEADBEEF,3,0,0,0);         vex[16] = mk_ex(1,1,0,0,0,0,0,0,0,1,'h40,'hDEADBEEF,3);
        vin[17] = mk_in(1,0,0,1,1,'h40,'hDEADBEEF,3,1,0,0);         vex[17] = mk_ex(1,1,0,0,0,0,0,0,0,1,'h40,'hDEADBEEF,3);
        vin[18] = mk_in(1,0,0,1,1,'h40,'hDEADBEEF,3,0,1,'hCAFE0001); vex[18] = mk_ex(0,1,0,1,0,1,0,0,'hCAFE0001,0,0,0,0);
        vin[19] = mk_in(1,0,0,0,0,0,0,0,0,0,0);                     vex[19] = mk_ex(0,0,0,0,0,0,0,0,0,0,0,0,0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst_n = vin[i].rs;
            bus.if_req = vin[i].ir; bus.if_addr = vin[i].ia;
            bus.d_req = vin[i].dr; bus.d_we = vin[i].dw; bus.d_addr = vin[i].da;
            bus.d_wdata = vin[i].dwd; bus.d_be = vin[i].dbe;
            bus.mem_gnt = vin[i].mg; bus.mem_rvalid = vin[i].mv; bus.mem_rdata = vin[i].md;
            #1;
            chk1($sformatf("r%0d mem_req", i), bus.mem_req, vex[i].mreq);
            chk1($sformatf("r%0d busy", i), bus.busy, vex[i].busy);
            chk1($sformatf("r%0d if_gnt", i), bus.if_gnt, vex[i].ig);
            chk1($sformatf("r%0d d_gnt", i), bus.d_gnt, vex[i].dg);
            chk1($sformatf("r%0d if_rvalid", i), bus.if_rvalid, vex[i].iv);
            chk1($sformatf("r%0d d_rvalid", i), bus.d_rvalid, vex[i].dv);
            chk1($sformatf("r%0d err", i), bus.err, vex[i].err);
            chk32($sformatf("r%0d if_rdata", i), bus.if_rdata, vex[i].ird);
            chk32($sformatf("r%0d d_rdata", i), bus.d_rdata, vex[i].drd);
            if (vex[i].mreq || !vin[i].rs) begin
                chk1($sformatf("r%0d mem_we", i), bus.mem_we, vex[i].we);
                chk32($sformatf("r%0d mem_addr", i), bus.mem_addr, vex[i].addr);
                chk32($sformatf("r%0d mem_wdata", i), bus.mem_wdata, vex[i].wd);
                chk32($sformatf("r%0d mem_be", i), 32'(bus.mem_be), 32'(vex[i].be));
            end
        end

        // Round-robin: both held, memory always ready; last owner was D.
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 32'h500;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h600; bus.d_be = 4'hF;
        bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h77;
        bubbles = 0;
        for (int c = 0; c < 40 && owners.size() < 6; c++) begin
            @(negedge clk); #1;
            if (bus.if_gnt) owners.push_back(0);
            if (bus.d_gnt) owners.push_back(1);
            if (owners.size() > 0 && !bus.busy) bubbles++;
        end
        chk32("rr grant count", 32'(owners.size()), 32'd6);
        for (int k = 0; k < owners.size() && k < 6; k++)
            chk32($sformatf("rr owner %0d", k), 32'(owners[k]), 32'(k % 2));
        chk32("rr idle bubbles", 32'(bubbles), 32'd0);

        // Timeout on a load; then a stray response must be ignored.
        do_reset();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h80; bus.d_be = 4'hF;
        bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h12345678;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk); #1;
            if (bus.d_gnt) seen = 1;
        end
        chk1("to d_gnt seen", seen, 1'b1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            chk1($sformatf("to rsp%0d d_rvalid", k), bus.d_rvalid, k == 4);
            chk1($sformatf("to rsp%0d err", k), bus.err, k == 4);
            if (k == 4) chk32("to d_rdata", bus.d_rdata, 32'h0);
        end
        @(negedge clk);
        bus.d_req = 1'b0; bus.mem_rvalid = 1'b1;
        #1;
        chk1("to stray d_rvalid", bus.d_rvalid, 1'b0);
        chk1("to stray if_rvalid", bus.if_rvalid, 1'b0);
        chk1("to stray err", bus.err, 1'b0);
        chk1("to stray busy", bus.busy, 1'b0);

        // Reset mid-RSP: a completed fetch first makes last owner IF.
        do_reset();
        bus.if_req = 1'b1; bus.if_addr = 32'h700; bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk); #1;
            if (bus.if_gnt) seen = 1;
        end
        chk1("rst fetch gnt seen", seen, 1'b1);
        @(negedge clk);
        bus.if_req = 1'b0; bus.mem_rvalid = 1'b0;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h900; bus.d_wdata = 32'h55; bus.d_be = 4'h1;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk); #1;
            if (bus.d_gnt) seen = 1;
        end
        chk1("rst load gnt seen", seen, 1'b1);
        @(negedge clk);
        rst_n = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hFFFFFFFF;
        #1;
        check_all_zero("rst mid");
        @(negedge clk);
        rst_n = 1'b1; bus.mem_rvalid = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 32'h704;
        first = -1;
        for (int c = 0; c < 10 && first < 0; c++) begin
            @(negedge clk); #1;
            if (bus.if_gnt) first = 0;
            else if (bus.d_gnt) first = 1;
        end
        chk32("rst tie winner", 32'(first), 32'd0);

        // Randomized traffic against the reference model.
        do_reset();
        m_busy = 0; m_granted = 0; m_ig = 0; m_dg = 0; m_prev = 1; m_wait = 0; m_own = 0;
        m_we = 0; m_addr = 0; m_wd = 0; m_be = 0;
        rq_if = 0; rq_d = 0; rq_dw = 0; rq_ia = 0; rq_da = 0; rq_dwd = 0; rq_dbe = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            bit mg, mv, rsp, abort, done, ig_n, dg_n, e_mreq, e_iv, e_dv;
            logic [31:0] md, e_ird, e_drd;
            int w;
            @(negedge clk);
            mg = 1'($urandom_range(0, 1));
            mv = ($urandom_range(0, 3) == 0);
            md = $urandom;
            bus.if_req = rq_if; bus.if_addr = rq_ia;
            bus.d_req = rq_d; bus.d_we = rq_dw; bus.d_addr = rq_da; bus.d_wdata = rq_dwd; bus.d_be = rq_dbe;
            bus.mem_gnt = mg; bus.mem_rvalid = mv; bus.mem_rdata = md;
            #1;
            rsp    = m_busy && m_granted;
            abort  = rsp && !mv && (m_wait == TO);
            done   = rsp && (mv || abort);
            e_mreq = m_busy && !m_granted;
            e_iv   = done && m_own == 0;
            e_dv   = done && m_own == 1;
            e_ird  = (rsp && m_own == 0 && !abort) ? md : 32'h0;
            e_drd  = (rsp && m_own == 1 && !abort) ? md : 32'h0;
            chk1($sformatf("rnd%0d mem_req", cyc), bus.mem_req, e_mreq);
            chk1($sformatf("rnd%0d busy", cyc), bus.busy, m_busy);
            chk1($sformatf("rnd%0d if_gnt", cyc), bus.if_gnt, m_ig);
            chk1($sformatf("rnd%0d d_gnt", cyc), bus.d_gnt, m_dg);
            chk1($sformatf("rnd%0d if_rvalid", cyc), bus.if_rvalid, e_iv);
            chk1($sformatf("rnd%0d d_rvalid", cyc), bus.d_rvalid, e_dv);
            chk1($sformatf("rnd%0d err", cyc), bus.err, abort);
            chk32($sformatf("rnd%0d if_rdata", cyc), bus.if_rdata, e_ird);
            chk32($sformatf("rnd%0d d_rdata", cyc), bus.d_rdata, e_drd);
            if (e_mreq) begin
                chk1($sformatf("rnd%0d mem_we", cyc), bus.mem_we, m_we);
                chk32($sformatf("rnd%0d mem_addr", cyc), bus.mem_addr, m_addr);
                chk32($sformatf("rnd%0d mem_wdata", cyc), bus.mem_wdata, m_wd);
                chk32($sformatf("rnd%0d mem_be", cyc), 32'(bus.mem_be), 32'(m_be));
            end
            ig_n = e_mreq && mg && m_own == 0;
            dg_n = e_mreq && mg && m_own == 1;
            if (!m_busy) begin
                w = pick(rq_if, rq_d, m_prev);
                if (w >= 0) model_start(w);
            end else if (!m_granted) begin
                if (mg) begin m_granted = 1; m_wait = 0; end
            end else if (done) begin
                m_prev = m_own;
                if (abort) m_busy = 0;
                else begin
                    w = pick(rq_if && m_own != 0, rq_d && m_own != 1, m_prev);
                    if (w >= 0) model_start(w);
                    else m_busy = 0;
                end
            end else begin
                m_wait++;
            end
            m_ig = ig_n; m_dg = dg_n;
            if (e_iv) rq_if = 0;
            if (e_dv) rq_d = 0;
            if (!rq_if && $urandom_range(0, 1) == 1) begin
                rq_if = 1; rq_ia = $urandom & 32'hFFFF_FFFC;
            end
            if (!rq_d && $urandom_range(0, 1) == 1) begin
                rq_d = 1; rq_dw = 1'($urandom_range(0, 1)); rq_da = $urandom;
                rq_dwd = $urandom; rq_dbe = 4'($urandom_range(0, 15));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
